// File: rtl/pvt_scan_scheduler.sv
// Walks every enabled (group, type) PVT sensor slot, enables one sensor at a time and
// turns each valid sample or timeout into a single result beat.
module pvt_scan_scheduler #(
  parameter int NO_OF_GROUPS   = 25,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2,
  localparam int GRP_W = (NO_OF_GROUPS > 1) ? $clog2(NO_OF_GROUPS) : 1
) (
  input  logic                    s_apb_clk,
  input  logic                    s_apb_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    continuous,
  input  logic [NO_OF_GROUPS-1:0] group_mask,
  input  logic [2:0]              type_mask,
  input  logic                    meas_valid,
  input  logic [15:0]             meas_data,
  output logic                    meas_en,
  output logic [GRP_W-1:0]        meas_group,
  output logic [1:0]              meas_type,
  output logic                    res_valid,
  output logic [GRP_W-1:0]        res_group,
  output logic [1:0]              res_type,
  output logic [15:0]             res_data,
  output logic                    res_timeout,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              timeout_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WAIT, S_STORE, S_GAP, S_DONE
  } state_t;

  state_t                  state_q;
  logic [NO_OF_GROUPS-1:0] group_mask_q;
  logic [2:0]              type_mask_q;
  logic [GRP_W-1:0]        ptr_grp_q;
  logic [1:0]              ptr_typ_q;
  logic [WCNT_W-1:0]       wait_cnt_q;
  logic [GCNT_W-1:0]       gap_cnt_q;
  logic                    meas_en_q;
  logic [GRP_W-1:0]        meas_group_q;
  logic [1:0]              meas_type_q;
  logic                    res_valid_q;
  logic [GRP_W-1:0]        res_group_q;
  logic [1:0]              res_type_q;
  logic [15:0]             res_data_q;
  logic                    res_timeout_q;
  logic                    busy_q;
  logic                    done_q;
  logic [7:0]              timeout_cnt_q;

  logic [GRP_W-1:0] ptr_grp_d;
  logic [1:0]       ptr_typ_d;
  logic             slot_hit;
  logic             last_slot;
  logic             wait_expired;

  // Slot order is P,V,T inside a group, groups ascending; wrap is decided by last_slot.
  always_comb begin
    ptr_grp_d = ptr_grp_q;
    ptr_typ_d = ptr_typ_q + 2'd1;
    if (ptr_typ_q == 2'd2) begin
      ptr_typ_d = 2'd0;
      ptr_grp_d = ptr_grp_q + 1'b1;
    end
  end

  assign slot_hit     = group_mask_q[ptr_grp_q] & type_mask_q[ptr_typ_q];
  assign last_slot    = (ptr_grp_q == GRP_W'(NO_OF_GROUPS - 1)) && (ptr_typ_q == 2'd2);
  assign wait_expired = (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge s_apb_clk or posedge s_apb_rst) begin
    if (s_apb_rst) begin
      state_q       <= S_IDLE;
      group_mask_q  <= '0;
      type_mask_q   <= '0;
      ptr_grp_q     <= '0;
      ptr_typ_q     <= '0;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      meas_en_q     <= 1'b0;
      meas_group_q  <= '0;
      meas_type_q   <= '0;
      res_valid_q   <= 1'b0;
      res_group_q   <= '0;
      res_type_q    <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q   <= S_IDLE;
        meas_en_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              group_mask_q  <= group_mask;
              type_mask_q   <= type_mask;
              timeout_cnt_q <= '0;
              ptr_grp_q     <= '0;
              ptr_typ_q     <= '0;
              busy_q        <= 1'b1;
              state_q       <= (group_mask == '0 || type_mask == '0) ? S_DONE : S_SELECT;
            end
          end
          S_SELECT: begin
            if (slot_hit) begin
              meas_en_q    <= 1'b1;
              meas_group_q <= ptr_grp_q;
              meas_type_q  <= ptr_typ_q;
              wait_cnt_q   <= '0;
              state_q      <= S_WAIT;
            end else if (last_slot) begin
              if (continuous) begin
                ptr_grp_q <= '0;
                ptr_typ_q <= '0;
              end else begin
                state_q <= S_DONE;
              end
            end else begin
              ptr_grp_q <= ptr_grp_d;
              ptr_typ_q <= ptr_typ_d;
            end
          end
          S_WAIT: begin
            // A sample arriving on the terminal-count cycle still counts as valid.
            if (meas_valid || wait_expired) begin
              meas_en_q     <= 1'b0;
              res_valid_q   <= 1'b1;
              res_group_q   <= meas_group_q;
              res_type_q    <= meas_type_q;
              res_data_q    <= meas_valid ? meas_data : 16'd0;
              res_timeout_q <= !meas_valid;
              if (!meas_valid && timeout_cnt_q != 8'hFF)
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
              state_q <= S_STORE;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
          S_STORE: begin
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end
          S_GAP: begin
            if (gap_cnt_q == GCNT_W'(GAP_CYCLES - 1)) begin
              if (last_slot) begin
                ptr_grp_q <= '0;
                ptr_typ_q <= '0;
                state_q   <= continuous ? S_SELECT : S_DONE;
              end else begin
                ptr_grp_q <= ptr_grp_d;
                ptr_typ_q <= ptr_typ_d;
                state_q   <= S_SELECT;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign meas_en     = meas_en_q;
  assign meas_group  = meas_group_q;
  assign meas_type   = meas_type_q;
  assign res_valid   = res_valid_q;
  assign res_group   = res_group_q;
  assign res_type    = res_type_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_pvt_scan_scheduler.sv
// Directed bench for pvt_scan_scheduler with 4 groups, 16-cycle timeout and 2-cycle gap.
module tb_pvt_scan_scheduler;
  localparam int N  = 4;
  localparam int GW = 2;

  logic          s_apb_clk = 1'b0;
  logic          s_apb_rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [N-1:0]  group_mask = '0;
  logic [2:0]    type_mask = '0;
  logic          meas_valid = 1'b0;
  logic [15:0]   meas_data = '0;
  logic          meas_en, res_valid, res_timeout, busy, done;
  logic [GW-1:0] meas_group, res_group;
  logic [1:0]    meas_type, res_type;
  logic [15:0]   res_data;
  logic [7:0]    timeout_cnt;

  int total = 0;
  int bad   = 0;

  pvt_scan_scheduler #(.NO_OF_GROUPS(N), .TIMEOUT_CYCLES(16), .GAP_CYCLES(2)) dut (
    .s_apb_clk(s_apb_clk), .s_apb_rst(s_apb_rst), .start(start), .abort(abort),
    .continuous(continuous), .group_mask(group_mask), .type_mask(type_mask),
    .meas_valid(meas_valid), .meas_data(meas_data), .meas_en(meas_en),
    .meas_group(meas_group), .meas_type(meas_type), .res_valid(res_valid),
    .res_group(res_group), .res_type(res_type), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy), .done(done), .timeout_cnt(timeout_cnt)
  );

  always #5 s_apb_clk = ~s_apb_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge s_apb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  // Ticks until meas_en rises and checks the cycle count and the selected slot.
  task automatic wait_en(input string tag, input int exp_lat, input int g, input int t);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (meas_en !== 1'b1 && n < 64);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_grp"}, meas_group, g);
    chk({tag, "_typ"}, meas_type, t);
    $display("slot %s grp=%0d typ=%0d lat=%0d", tag, meas_group, meas_type, n);
  endtask

  task automatic finish_slot(input string tag, input int dly, input logic [15:0] d,
                             input int g, input int t);
    repeat (dly) tick();
    meas_valid = 1'b1;
    meas_data  = d;
    tick();
    meas_valid = 1'b0;
    meas_data  = '0;
    chk({tag, "_rv"}, res_valid, 1);
    chk({tag, "_rgrp"}, res_group, g);
    chk({tag, "_rtyp"}, res_type, t);
    chk({tag, "_rdata"}, res_data, d);
    chk({tag, "_rto"}, res_timeout, 0);
    chk({tag, "_en_off"}, meas_en, 0);
    $display("result %s grp=%0d typ=%0d data=%h", tag, res_group, res_type, res_data);
  endtask

  // Ticks until done, checking its latency, that no result appears and that busy drops.
  task automatic wait_done(input string tag, input int exp_lat);
    int n, nres;
    n = 0;
    nres = 0;
    do begin
      tick();
      n++;
      if (res_valid === 1'b1) nres++;
    end while (done !== 1'b1 && n < 200);
    chk({tag, "_done_lat"}, n, exp_lat);
    chk({tag, "_no_res"}, nres, 0);
    chk({tag, "_busy_low"}, busy, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    $display("done %s lat=%0d", tag, n);
  endtask

  initial begin
    int n, nres;
    repeat (2) tick();
    s_apb_rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_en", meas_en, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    chk("rst_rdata", res_data, 0);

    // T1: full scan, every slot answered 5 cycles after enable
    group_mask = 4'b1111; type_mask = 3'b111; continuous = 1'b0;
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      wait_en("t1", (i == 0) ? 1 : 4, i / 3, i % 3);
      finish_slot("t1", 5, 16'h1000 + 16'(i), i / 3, i % 3);
    end
    wait_done("t1", 4);

    // T2: one slot (2,T), eight skipped slots ahead of it
    group_mask = 4'b0100; type_mask = 3'b100;
    pulse_start();
    wait_en("t2", 9, 2, 2);
    finish_slot("t2", 5, 16'hA55A, 2, 2);
    wait_done("t2", 7);

    // T3: sensor never answers; result on 17th cycle counting the WAIT entry cycle
    group_mask = 4'b0001; type_mask = 3'b001;
    meas_data = 16'hBEEF;
    pulse_start();
    wait_en("t3", 1, 0, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (res_valid !== 1'b1 && n < 40);
    chk("t3_to_lat", n, 16);
    chk("t3_rto", res_timeout, 1);
    chk("t3_rdata", res_data, 0);
    chk("t3_tcnt", timeout_cnt, 1);
    $display("result t3 timeout lat=%0d tcnt=%0d", n, timeout_cnt);
    meas_data = '0;
    wait_done("t3", 15);

    // T5a: valid on terminal count wins; start while busy is ignored
    pulse_start();
    wait_en("t5", 1, 0, 0);
    repeat (3) tick();
    group_mask = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("t5_still_en", meas_en, 1);
    meas_valid = 1'b1; meas_data = 16'h5A5A;
    tick();
    meas_valid = 1'b0; meas_data = '0;
    chk("t5_rv", res_valid, 1);
    chk("t5_rto", res_timeout, 0);
    chk("t5_rdata", res_data, 16'h5A5A);
    chk("t5_tcnt_clr", timeout_cnt, 0);
    $display("result t5 terminal-count data=%h", res_data);
    wait_done("t5", 15);

    // T5b: asynchronous reset while waiting on (2,T)
    group_mask = 4'b0100; type_mask = 3'b100;
    pulse_start();
    wait_en("t5r", 9, 2, 2);
    #2 s_apb_rst = 1'b1;
    #1;
    chk("t5r_en", meas_en, 0);
    chk("t5r_busy", busy, 0);
    chk("t5r_grp", meas_group, 0);
    chk("t5r_typ", meas_type, 0);
    chk("t5r_rdata", res_data, 0);
    #2 s_apb_rst = 1'b0;
    tick();
    chk("t5r_idle", busy, 0);
    chk("t5r_norv", res_valid, 0);

    // T4: continuous over (1,V),(3,V), stop after second pass
    group_mask = 4'b1010; type_mask = 3'b010; continuous = 1'b1;
    pulse_start();
    wait_en("t4a", 5, 1, 1);
    finish_slot("t4a", 2, 16'h0011, 1, 1);
    wait_en("t4b", 9, 3, 1);
    finish_slot("t4b", 3, 16'h0031, 3, 1);
    wait_en("t4c", 9, 1, 1);
    continuous = 1'b0;
    finish_slot("t4c", 1, 16'h0111, 1, 1);
    wait_en("t4d", 9, 3, 1);
    finish_slot("t4d", 4, 16'h0331, 3, 1);
    wait_done("t4", 5);

    // T4 abort during WAIT, coinciding with meas_valid
    pulse_start();
    wait_en("t4x", 5, 1, 1);
    repeat (2) tick();
    abort = 1'b1; meas_valid = 1'b1; meas_data = 16'h1234;
    tick();
    abort = 1'b0; meas_valid = 1'b0; meas_data = '0;
    chk("t4x_en", meas_en, 0);
    chk("t4x_busy", busy, 0);
    chk("t4x_rv", res_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4x_nodone", done, 0);
      chk("t4x_norv", res_valid, 0);
    end
    $display("abort t4x busy=%0d en=%0d", busy, meas_en);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    tick();
    chk("sa_busy2", busy, 0);

    // T6a: empty masks finish immediately
    group_mask = 4'b0000; type_mask = 3'b111;
    pulse_start();
    wait_done("t6g", 1);
    group_mask = 4'b1111; type_mask = 3'b000;
    pulse_start();
    wait_done("t6t", 1);

    // T6b: 300 consecutive timeouts saturate the counter
    type_mask = 3'b111; continuous = 1'b1;
    pulse_start();
    n = 0;
    nres = 0;
    while (nres < 300 && n < 20000) begin
      tick();
      n++;
      if (res_valid === 1'b1) begin
        nres++;
        if (nres == 200) chk("t6_tcnt200", timeout_cnt, 200);
      end
    end
    chk("t6_nres", nres, 300);
    chk("t6_tcnt_sat", timeout_cnt, 255);
    chk("t6_rto", res_timeout, 1);
    $display("sat t6 results=%0d tcnt=%0d", nres, timeout_cnt);
    abort = 1'b1;
    tick();
    abort = 1'b0; continuous = 1'b0;
    chk("t6_abort_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
